// File: rtl/vram_arb_pkg.sv
// Shared types and default sizes for the text-mode VRAM arbiter.
package vram_arb_pkg;

   localparam int unsigned DEF_ADDR_W    = 10;
   localparam int unsigned DEF_DATA_W    = 32;
   localparam int unsigned DEF_MAX_DEFER = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_DISP = 2'd1,
      OWN_CPU  = 2'd2
   } owner_t;

   typedef enum logic [0:0] {
      C_IDLE = 1'b0,
      C_RD   = 1'b1
   } cpu_state_t;

endpackage

// File: rtl/arb_defer_counter.sv
// Counts consecutive cycles a pending CPU access loses to the display;
// force_cpu asserts once the count saturates at MAX_DEFER.
module arb_defer_counter #(
   parameter int unsigned MAX_DEFER = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic eligible,
   input  logic lost,
   input  logic granted,
   output logic force_cpu
);

   localparam int unsigned CNT_W = $clog2(MAX_DEFER + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!eligible || granted) begin
         cnt_d = '0;
      end else if (lost && (cnt_q != CNT_W'(MAX_DEFER))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_cpu = (cnt_q == CNT_W'(MAX_DEFER));

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetches have fixed priority, the CPU Avalon
// slave is guaranteed a slot after MAX_DEFER consecutive losses.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned MAX_DEFER = DEF_MAX_DEFER
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic                avl_read,
   input  logic                avl_write,
   input  logic [ADDR_W-1:0]   avl_address,
   input  logic [DATA_W/8-1:0] avl_byteenable,
   input  logic [DATA_W-1:0]   avl_writedata,
   output logic [DATA_W-1:0]   avl_readdata,
   output logic                avl_waitrequest,
   input  logic                disp_req,
   input  logic [ADDR_W-1:0]   disp_addr,
   output logic                disp_gnt,
   output logic [DATA_W-1:0]   disp_rdata,
   output logic                disp_rvalid,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic                ram_we,
   output logic [DATA_W/8-1:0] ram_be,
   output logic [DATA_W-1:0]   ram_wdata,
   input  logic [DATA_W-1:0]   ram_rdata
);

   cpu_state_t          state_q, state_d;
   owner_t              rd_owner_q, rd_owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   logic cpu_wr, cpu_rd, cpu_eligible, cpu_win, disp_win, force_cpu, cpu_lost;

   // A simultaneous read+write is treated as a write only.
   always_comb begin
      cpu_wr       = avl_write;
      cpu_rd       = avl_read & ~avl_write;
      cpu_eligible = reset_reset_n & (state_q == C_IDLE) & (avl_read | avl_write);
      disp_win     = reset_reset_n & disp_req & ~(cpu_eligible & force_cpu);
      cpu_win      = cpu_eligible & ~disp_win;
      cpu_lost     = cpu_eligible & disp_win;
   end

   arb_defer_counter #(
      .MAX_DEFER (MAX_DEFER)
   ) u_defer (
      .clk       (clk_clk),
      .reset_n   (reset_reset_n),
      .eligible  (cpu_eligible),
      .lost      (cpu_lost),
      .granted   (cpu_win),
      .force_cpu (force_cpu)
   );

   always_comb begin
      state_d    = state_q;
      rd_owner_d = OWN_NONE;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      ram_we     = 1'b0;
      ram_be     = '0;
      ram_addr   = addr_q;
      ram_wdata  = wdata_q;
      disp_gnt   = 1'b0;

      if (disp_win) begin
         disp_gnt   = 1'b1;
         ram_addr   = disp_addr;
         addr_d     = disp_addr;
         rd_owner_d = OWN_DISP;
      end else if (cpu_win) begin
         ram_addr = avl_address;
         addr_d   = avl_address;
         if (cpu_wr) begin
            ram_we    = 1'b1;
            ram_be    = avl_byteenable;
            ram_wdata = avl_writedata;
            wdata_d   = avl_writedata;
         end else if (cpu_rd) begin
            rd_owner_d = OWN_CPU;
            state_d    = C_RD;
         end
      end

      if (state_q == C_RD) begin
         state_d = C_IDLE;
      end
   end

   always_comb begin
      avl_waitrequest = 1'b0;
      avl_readdata    = '0;
      disp_rvalid     = 1'b0;
      disp_rdata      = '0;
      if (!reset_reset_n) begin
         avl_waitrequest = 1'b1;
      end else begin
         if (state_q == C_RD) begin
            avl_readdata = ram_rdata;
         end else if (avl_read || avl_write) begin
            avl_waitrequest = ~(cpu_win & cpu_wr);
         end
         if (rd_owner_q == OWN_DISP) begin
            disp_rvalid = 1'b1;
            disp_rdata  = ram_rdata;
         end
      end
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q    <= C_IDLE;
         rd_owner_q <= OWN_NONE;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         rd_owner_q <= rd_owner_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural 1-cycle-latency VRAM.
module tb_vram_arbiter;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 32;

   logic                clk_clk = 1'b0;
   logic                reset_reset_n;
   logic                avl_read, avl_write;
   logic [ADDR_W-1:0]   avl_address;
   logic [DATA_W/8-1:0] avl_byteenable;
   logic [DATA_W-1:0]   avl_writedata;
   logic [DATA_W-1:0]   avl_readdata;
   logic                avl_waitrequest;
   logic                disp_req;
   logic [ADDR_W-1:0]   disp_addr;
   logic                disp_gnt;
   logic [DATA_W-1:0]   disp_rdata;
   logic                disp_rvalid;
   logic [ADDR_W-1:0]   ram_addr;
   logic                ram_we;
   logic [DATA_W/8-1:0] ram_be;
   logic [DATA_W-1:0]   ram_wdata;
   logic [DATA_W-1:0]   ram_rdata;

   int checks   = 0;
   int failures = 0;

   logic [DATA_W-1:0] cpu_q[$];
   logic [DATA_W-1:0] disp_q[$];
   logic [DATA_W-1:0] mem [1024];

   always #5 clk_clk = ~clk_clk;

   vram_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MAX_DEFER (4)
   ) dut (
      .clk_clk         (clk_clk),
      .reset_reset_n   (reset_reset_n),
      .avl_read        (avl_read),
      .avl_write       (avl_write),
      .avl_address     (avl_address),
      .avl_byteenable  (avl_byteenable),
      .avl_writedata   (avl_writedata),
      .avl_readdata    (avl_readdata),
      .avl_waitrequest (avl_waitrequest),
      .disp_req        (disp_req),
      .disp_addr       (disp_addr),
      .disp_gnt        (disp_gnt),
      .disp_rdata      (disp_rdata),
      .disp_rvalid     (disp_rvalid),
      .ram_addr        (ram_addr),
      .ram_we          (ram_we),
      .ram_be          (ram_be),
      .ram_wdata       (ram_wdata),
      .ram_rdata       (ram_rdata)
   );

   always @(posedge clk_clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         end
      end
      ram_rdata <= mem[ram_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Contents seen by the display after the directed CPU writes to 0x005/0x006.
   function automatic logic [31:0] exp_word(input int a);
      if (a == 5) return 32'hDEAD3344;
      if (a == 6) return 32'h0BADF00D;
      return 32'hA5A50000 | 32'(a);
   endfunction

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic cpu_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be,
                            input logic also_read);
      avl_write      = 1'b1;
      avl_read       = also_read;
      avl_address    = a;
      avl_writedata  = d;
      avl_byteenable = be;
      @(negedge clk_clk);
      check("wr_waitrequest", 32'(avl_waitrequest), 32'd0);
      check("wr_ram_we", 32'(ram_we), 32'd1);
      check("wr_ram_be", 32'(ram_be), 32'(be));
      check("wr_ram_addr", 32'(ram_addr), 32'(a));
      check("wr_ram_wdata", ram_wdata, d);
      tick();
      avl_write = 1'b0;
      avl_read  = 1'b0;
   endtask

   task automatic cpu_read(input logic [9:0] a, input logic [31:0] d, input int exp_waits);
      int waits = 0;
      logic done = 1'b0;
      cpu_q.push_back(d);
      avl_read    = 1'b1;
      avl_address = a;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk_clk);
         if (avl_waitrequest) waits++;
         else done = 1'b1;
         tick();
      end
      avl_read = 1'b0;
      check("rd_completed", 32'(done), 32'd1);
      check("rd_wait_cycles", 32'(waits), 32'(exp_waits));
   endtask

   task automatic display_stream();
      int cnt = 0;
      int misses = 0;
      logic g;
      disp_addr = '0;
      disp_req  = 1'b1;
      for (int cyc = 0; cyc < 200 && cnt < 80; cyc++) begin
         @(negedge clk_clk);
         g = disp_gnt;
         if (g) begin
            disp_q.push_back(exp_word(cnt));
            check("disp_ram_addr", 32'(ram_addr), 32'(cnt));
         end else begin
            misses++;
         end
         tick();
         if (g) begin
            cnt++;
            disp_addr = 10'(cnt);
            if (cnt == 80) disp_req = 1'b0;
         end
      end
      disp_req = 1'b0;
      check("disp_grants", 32'(cnt), 32'd80);
      check("disp_lost_cycles", 32'(misses), 32'd1);
   endtask

   task automatic cpu_during_stream();
      logic exp_wait [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic exp_gnt  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      repeat (10) tick();
      cpu_q.push_back(32'hDEAD3344);
      avl_read    = 1'b1;
      avl_address = 10'h005;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_clk);
         check("defer_waitrequest", 32'(avl_waitrequest), 32'(exp_wait[i]));
         check("defer_disp_gnt", 32'(disp_gnt), 32'(exp_gnt[i]));
         if (i == 4) check("defer_cpu_addr", 32'(ram_addr), 32'h005);
         tick();
      end
      avl_read = 1'b0;
   endtask

   // Monitor: checks rvalid timing every cycle and pops the scoreboards on returns.
   initial begin
      logic prev_gnt = 1'b0;
      forever begin
         @(negedge clk_clk);
         check("disp_rvalid_timing", 32'(disp_rvalid), 32'(prev_gnt & reset_reset_n));
         if (disp_rvalid) begin
            if (disp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL disp_unexpected_rvalid actual=1 required=0");
            end else begin
               check("disp_rdata", disp_rdata, disp_q.pop_front());
            end
         end
         if (avl_read && !avl_write && !avl_waitrequest) begin
            if (cpu_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL cpu_unexpected_completion actual=1 required=0");
            end else begin
               check("cpu_readdata", avl_readdata, cpu_q.pop_front());
            end
         end
         prev_gnt = disp_gnt;
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A50000 | 32'(i);
      reset_reset_n  = 1'b0;
      avl_read       = 1'b1;
      avl_write      = 1'b0;
      avl_address    = 10'h005;
      avl_byteenable = '0;
      avl_writedata  = '0;
      disp_req       = 1'b1;
      disp_addr      = 10'h010;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk_clk);
         check("rst_waitrequest", 32'(avl_waitrequest), 32'd1);
         check("rst_disp_gnt", 32'(disp_gnt), 32'd0);
         check("rst_ram_we", 32'(ram_we), 32'd0);
         check("rst_ram_be", 32'(ram_be), 32'd0);
         check("rst_readdata", avl_readdata, 32'd0);
         check("rst_ram_addr", 32'(ram_addr), 32'd0);
      end
      tick();
      reset_reset_n = 1'b1;
      avl_read      = 1'b0;
      disp_req      = 1'b0;

      cpu_write(10'h005, 32'hDEADBEEF, 4'hF, 1'b0);
      cpu_read(10'h005, 32'hDEADBEEF, 1);
      cpu_write(10'h005, 32'h11223344, 4'b0011, 1'b0);
      cpu_read(10'h005, 32'hDEAD3344, 1);
      cpu_write(10'h005, 32'hFFFFFFFF, 4'b0000, 1'b0);
      cpu_read(10'h005, 32'hDEAD3344, 1);
      cpu_write(10'h006, 32'h0BADF00D, 4'hF, 1'b1);
      @(negedge clk_clk);
      check("rw_no_read_pending", 32'(avl_waitrequest), 32'd0);
      tick();
      cpu_read(10'h006, 32'h0BADF00D, 1);

      fork
         display_stream();
         cpu_during_stream();
      join
      repeat (3) tick();
      check("disp_queue_drained", 32'(disp_q.size()), 32'd0);
      check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);

      // Read granted, then reset lands in the return cycle: the read is dropped.
      avl_read    = 1'b1;
      avl_address = 10'h006;
      @(negedge clk_clk);
      check("flight_grant_wait", 32'(avl_waitrequest), 32'd1);
      check("flight_grant_addr", 32'(ram_addr), 32'h006);
      tick();
      reset_reset_n = 1'b0;
      @(negedge clk_clk);
      check("flight_rst_wait", 32'(avl_waitrequest), 32'd1);
      check("flight_rst_readdata", avl_readdata, 32'd0);
      check("flight_rst_ram_we", 32'(ram_we), 32'd0);
      tick();
      reset_reset_n = 1'b1;
      avl_read      = 1'b0;
      @(negedge clk_clk);
      check("post_rst_idle_wait", 32'(avl_waitrequest), 32'd0);
      check("post_rst_ram_addr", 32'(ram_addr), 32'd0);
      tick();
      cpu_read(10'h006, 32'h0BADF00D, 1);
      repeat (2) tick();
      check("final_cpu_queue", 32'(cpu_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
